// File: rtl/pca_pkg.sv
// Shared definitions for the segmented pipelined carry adder.
// Holds the build width, the stage count helper and the per-stage payload record.
package pca_pkg;

  localparam int PCA_WIDTH = 32;
  localparam int PCA_SEG   = 8;

  function automatic int pca_stages(input int width, input int seg);
    return width / seg;
  endfunction

  localparam int STAGES = pca_stages(PCA_WIDTH, PCA_SEG);

  // lo_sum fills from the bottom one segment per stage; hi_a/hi_b ride along so
  // later stages still see the operand bits they have not resolved yet.
  typedef struct packed {
    logic                 valid;
    logic [PCA_WIDTH-1:0] lo_sum;
    logic [PCA_WIDTH-1:0] hi_a;
    logic [PCA_WIDTH-1:0] hi_b;
    logic                 carry;
    logic                 sub;
  } stage_t;

endpackage

// File: rtl/maj_carry_seg.sv
// One segment of majority-carry cells rippled together.
// Exposes the carry into the top bit so the last stage can derive signed overflow.
module maj_carry_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout     = c[SEG];
    c_msb_in = c[SEG - 1];
  end

endmodule

// File: rtl/seg_pipelined_carry_adder.sv
// WIDTH-bit add/subtract resolved SEG bits per pipeline stage, carry registered between stages.
// Valid/ready on both sides; bubbles collapse so a stalled pipe fills completely before in_ready drops.
module seg_pipelined_carry_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = PCA_WIDTH,
  parameter int SEG   = PCA_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NUM_STAGES = pca_stages(WIDTH, SEG);

  if ((SEG < 1) || ((WIDTH % SEG) != 0) || (WIDTH > PCA_WIDTH)) begin : g_bad_cfg
    $error("seg_pipelined_carry_adder: WIDTH must be a multiple of SEG and fit the package payload");
  end

  stage_t                src     [NUM_STAGES];
  stage_t                nxt     [NUM_STAGES];
  stage_t                stage_q [NUM_STAGES];
  logic [SEG-1:0]        seg_sum [NUM_STAGES];
  logic [NUM_STAGES-1:0] seg_cout;
  logic [NUM_STAGES-1:0] seg_cmsb;
  logic [NUM_STAGES-1:0] adv;
  logic                  cout_q;
  logic                  ovf_q;

  // Subtraction folds into the adder here: B is inverted and the carry-in forced high.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      src[k] = '0;
    end
    src[0].valid              = in_valid;
    src[0].hi_a[WIDTH-1:0]    = in_a;
    src[0].hi_b[WIDTH-1:0]    = in_sub ? ~in_b : in_b;
    src[0].carry              = in_sub | in_cin;
    src[0].sub                = in_sub;
    for (int k = 1; k < NUM_STAGES; k++) begin
      src[k] = stage_q[k - 1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_seg
    maj_carry_seg #(
      .SEG(SEG)
    ) u_seg (
      .a        (src[k].hi_a[k*SEG +: SEG]),
      .b        (src[k].hi_b[k*SEG +: SEG]),
      .cin      (src[k].carry),
      .sum      (seg_sum[k]),
      .cout     (seg_cout[k]),
      .c_msb_in (seg_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt[k]                      = src[k];
      nxt[k].lo_sum[k*SEG +: SEG] = seg_sum[k];
      nxt[k].carry                = seg_cout[k];
    end
  end

  // A stage may move when any stage at or below it in the pipe (toward the output) has room,
  // or the consumer is taking the head beat; computed as a running OR to avoid a feedback chain.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      room   = room | ~stage_q[k].valid;
      adv[k] = room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= '0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (adv[k]) begin
          if (src[k].valid) begin
            stage_q[k] <= nxt[k];
          end else begin
            stage_q[k].valid <= 1'b0;
          end
        end
      end
      if (adv[NUM_STAGES-1] && src[NUM_STAGES-1].valid) begin
        cout_q <= seg_cout[NUM_STAGES-1];
        ovf_q  <= seg_cout[NUM_STAGES-1] ^ seg_cmsb[NUM_STAGES-1];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = stage_q[NUM_STAGES-1].valid;
  assign out_sum   = stage_q[NUM_STAGES-1].lo_sum[WIDTH-1:0];
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  logic unused_tail;
  assign unused_tail = ^{stage_q[NUM_STAGES-1].hi_a, stage_q[NUM_STAGES-1].hi_b,
                         stage_q[NUM_STAGES-1].carry, stage_q[NUM_STAGES-1].sub};

endmodule
